// File: rtl/barrett_red60_q30_if.sv
// Handshake bundle for the 60-bit Barrett reducer: product in, residue out, modulus load.
// The stall port exists only when BARRETT_STALL_EN is defined.
interface barrett_red60_q30_if;
  logic [59:0] c_in;
  logic        valid_in;
  logic [29:0] q_in;
  logic [30:0] mu_in;
  logic        q_load;
`ifdef BARRETT_STALL_EN
  logic        stall;
`endif
  logic [29:0] r_out;
  logic        valid_out;
  logic        busy;
  logic        q_err;

`ifdef BARRETT_STALL_EN
  modport master (output c_in, valid_in, q_in, mu_in, q_load, stall,
                  input  r_out, valid_out, busy, q_err);
  modport slave  (input  c_in, valid_in, q_in, mu_in, q_load, stall,
                  output r_out, valid_out, busy, q_err);
`else
  modport master (output c_in, valid_in, q_in, mu_in, q_load,
                  input  r_out, valid_out, busy, q_err);
  modport slave  (input  c_in, valid_in, q_in, mu_in, q_load,
                  output r_out, valid_out, busy, q_err);
`endif
endinterface

// File: rtl/barrett_red60_q30.sv
// Five-stage Barrett reducer r = c mod q (c < q^2, 2^29 < q < 2^30), one result per clock.
// Optional BARRETT_STALL_EN adds a stall input that freezes the whole pipeline.
module barrett_red60_q30 #(
  parameter logic [29:0] Q_RST  = 30'h3FFF_C001,
  parameter logic [30:0] MU_RST = 31'd0
) (
  input logic             clk,
  input logic             rst,
  barrett_red60_q30_if.slave bus
);
  localparam int STAGES = 5;

  logic              adv;
  logic [STAGES:1]   vld_pipe;
  logic [29:0]       q_cur;
  logic [30:0]       mu_cur;
  logic              load_ok;
  logic [59:0]       c1;
  logic [30:0]       q3;
  logic [31:0]       c2, c3, p3, t4;
  logic [31:0]       q1x, q2x;
  logic [29:0]       r_out;
  logic              q_err;

`ifdef BARRETT_STALL_EN
  assign adv = ~bus.stall;
`else
  assign adv = 1'b1;
`endif

  assign bus.busy      = |vld_pipe;
  assign bus.valid_out = vld_pipe[STAGES];
  assign bus.r_out     = r_out;
  assign bus.q_err     = q_err;

  // Modulus may only change when nothing in flight could see a mixed q/mu.
  assign load_ok = bus.q_load & ~bus.busy & ~bus.valid_in;
  assign q1x     = {2'b00, q_cur};
  assign q2x     = {1'b0, q_cur, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_cur  <= Q_RST;
      mu_cur <= MU_RST;
      q_err  <= 1'b0;
    end else begin
      q_err <= bus.q_load & ~load_ok;
      if (load_ok) begin
        q_cur  <= bus.q_in;
        mu_cur <= bus.mu_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], bus.valid_in};
  end

  // Data registers only load behind a valid bit, so they hold while idle or stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c1    <= '0;
      q3    <= '0;
      c2    <= '0;
      p3    <= '0;
      c3    <= '0;
      t4    <= '0;
      r_out <= '0;
    end else if (adv) begin
      if (bus.valid_in) c1 <= bus.c_in;
      if (vld_pipe[1]) begin
        q3 <= 31'(({31'd0, c1[59:29]} * {31'd0, mu_cur}) >> 31);
        c2 <= c1[31:0];
      end
      if (vld_pipe[2]) begin
        p3 <= {1'b0, q3} * q1x;
        c3 <= c2;
      end
      if (vld_pipe[3]) t4 <= c3 - p3;
      // t < 3q, so at most two subtractions of q are needed.
      if (vld_pipe[4]) begin
        if (t4 >= q2x)      r_out <= 30'(t4 - q2x);
        else if (t4 >= q1x) r_out <= 30'(t4 - q1x);
        else                r_out <= t4[29:0];
      end
    end
  end
endmodule
